// File: rtl/wake_ctl.sv
// ============================================================================
// Module  : wake_ctl
// Purpose : VAD qualification (sync, mask, combine, debounce) and wake-pulse FSM
//           gating the DFE/ACO/WRD pipeline.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wake_ctl #(
    parameter int F_SYSTEM_CLK      = 16000000,
    parameter int N_VAD             = 2,
    parameter int VAD_MODE          = 0,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int HOLD_CYCLES       = F_SYSTEM_CLK,
    parameter int WAKE_PULSE_CYCLES = F_SYSTEM_CLK / 1000,
    parameter int COOLDOWN_CYCLES   = F_SYSTEM_CLK / 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_VAD-1:0] vad_i,
    input  logic [N_VAD-1:0] vad_mask_i,
    input  logic             wake_valid_i,
    input  logic             wake_i,
    output logic             en_o,
    output logic             wake_o,
    output logic [1:0]       state_o,
    output logic [7:0]       wake_count_o
);

    localparam int C_T_MAX0 = (HOLD_CYCLES > WAKE_PULSE_CYCLES) ? HOLD_CYCLES : WAKE_PULSE_CYCLES;
    localparam int C_T_MAX  = (C_T_MAX0 > COOLDOWN_CYCLES) ? C_T_MAX0 : COOLDOWN_CYCLES;
    localparam int TW       = $clog2(C_T_MAX + 1);
    localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [TW-1:0] C_HOLD_LD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] C_PULSE_LD = TW'(WAKE_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] C_COOL_LD  = TW'(COOLDOWN_CYCLES - 1);
    localparam logic [DW-1:0] C_DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACTIVE   = 2'd1;
    localparam logic [1:0] S_WAKE     = 2'd2;
    localparam logic [1:0] S_COOLDOWN = 2'd3;

    logic [N_VAD-1:0] sync1_q, sync2_q;
    logic             vad_raw;
    logic [DW-1:0]    db_cnt_q, db_cnt_d;
    logic             vad_db_q, vad_db_d;
    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [7:0]       count_q, count_d;
    logic             en_q, en_d;
    logic             wake_q, wake_d;

    // Two-flop synchroniser; vad_i is asynchronous to clk_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= vad_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (VAD_MODE == 0) begin : g_or
            assign vad_raw = |(sync2_q & vad_mask_i);
        end else begin : g_and
            // An all-zero mask must not read as "all channels active".
            assign vad_raw = (vad_mask_i != '0) && (&(sync2_q | ~vad_mask_i));
        end
    endgenerate

    always_comb begin
        db_cnt_d = '0;
        vad_db_d = vad_db_q;
        if (vad_raw != vad_db_q) begin
            if (db_cnt_q == C_DB_LAST) begin
                vad_db_d = vad_raw;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // One shared timer serves hold, pulse and cooldown, as only one is live per state.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (vad_db_q) begin
                    state_d = S_ACTIVE;
                    timer_d = C_HOLD_LD;
                end
            end
            S_ACTIVE: begin
                if (wake_valid_i && wake_i) begin
                    state_d = S_WAKE;
                    timer_d = C_PULSE_LD;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 1'b1;
                    end
                end else if (vad_db_q) begin
                    timer_d = C_HOLD_LD;
                end else if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_WAKE: begin
                if (timer_q == '0) begin
                    state_d = S_COOLDOWN;
                    timer_d = C_COOL_LD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
        en_d   = (state_d == S_ACTIVE);
        wake_d = (state_d == S_WAKE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            db_cnt_q <= '0;
            vad_db_q <= 1'b0;
            state_q  <= S_IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
            wake_q   <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            vad_db_q <= vad_db_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            en_q     <= en_d;
            wake_q   <= wake_d;
        end
    end

    assign en_o         = en_q;
    assign wake_o       = wake_q;
    assign state_o      = state_q;
    assign wake_count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_wake_ctl.sv
// ============================================================================
// Module  : tb_wake_ctl
// Purpose : Directed self-checking bench for wake_ctl (OR and AND instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wake_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] vad0, mask0, vad1, mask1;
    logic       wv0, wk0, wv1, wk1;
    logic       en0, wake0, en1, wake1;
    logic [1:0] st0, st1;
    logic [7:0] cnt0, cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wake_ctl #(
        .F_SYSTEM_CLK(16000000), .N_VAD(2), .VAD_MODE(0), .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10), .WAKE_PULSE_CYCLES(5), .COOLDOWN_CYCLES(8)
    ) u_dut_or (
        .clk_i(clk), .rst_n_i(rst_n), .vad_i(vad0), .vad_mask_i(mask0),
        .wake_valid_i(wv0), .wake_i(wk0), .en_o(en0), .wake_o(wake0),
        .state_o(st0), .wake_count_o(cnt0)
    );

    wake_ctl #(
        .F_SYSTEM_CLK(16000000), .N_VAD(2), .VAD_MODE(1), .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10), .WAKE_PULSE_CYCLES(5), .COOLDOWN_CYCLES(8)
    ) u_dut_and (
        .clk_i(clk), .rst_n_i(rst_n), .vad_i(vad1), .vad_mask_i(mask1),
        .wake_valid_i(wv1), .wake_i(wk1), .en_o(en1), .wake_o(wake1),
        .state_o(st1), .wake_count_o(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state0(input string tag, input logic [1:0] s);
        int k;
        k = 0;
        while (st0 !== s && k < 40) begin
            tick(1);
            k++;
        end
        check(tag, st0, s);
    endtask

    task automatic pulse_wake0();
        wv0 = 1'b1;
        wk0 = 1'b1;
        tick(1);
        wv0 = 1'b0;
        wk0 = 1'b0;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        vad0 = 2'b11; mask0 = 2'b11; wv0 = 1'b0; wk0 = 1'b0;
        vad1 = 2'b00; mask1 = 2'b11; wv1 = 1'b0; wk1 = 1'b0;

        // Reset state with VAD already asserted
        tick(3);
        check("rst_en", en0, 0);
        check("rst_wake", wake0, 0);
        check("rst_state", st0, 0);
        check("rst_count", cnt0, 0);
        rst_n = 1'b1;
        tick(6);
        check("lat_en_pre", en0, 0);
        tick(1);
        check("lat_en", en0, 1);
        check("lat_state", st0, 1);

        // Hold: vad_db falls 6 edges after drop, en stays 10 more
        vad0 = 2'b00;
        tick(15);
        check("hold_en_last", en0, 1);
        tick(1);
        check("hold_en_off", en0, 0);
        check("hold_state", st0, 0);

        // Glitch shorter than debounce on masked-in channel
        mask0 = 2'b01;
        vad0  = 2'b01;
        tick(3);
        vad0 = 2'b00;
        seen = 1'b0;
        repeat (20) begin
            tick(1);
            seen |= en0;
        end
        check("glitch_en", seen, 0);

        vad0 = 2'b01;
        tick(5);
        vad0 = 2'b00;
        tick(1);
        check("pulse5_en_pre", en0, 0);
        tick(1);
        check("pulse5_en", en0, 1);
        wait_state0("pulse5_idle", 2'd0);

        // Wake in ACTIVE
        vad0 = 2'b01;
        tick(7);
        check("act_en", en0, 1);
        wv0 = 1'b1;
        wk0 = 1'b0;
        tick(1);
        wv0 = 1'b0;
        check("nowake_state", st0, 1);
        check("nowake_wake", wake0, 0);
        pulse_wake0();
        check("wake_en", en0, 0);
        check("wake_o", wake0, 1);
        check("wake_state", st0, 2);
        check("wake_count1", cnt0, 1);
        tick(4);
        check("wake_last", wake0, 1);
        tick(1);
        check("wake_end", wake0, 0);
        check("cool_state", st0, 3);
        pulse_wake0();
        tick(6);
        check("cool_last", st0, 3);
        tick(1);
        check("cool_idle", st0, 0);
        check("cool_idle_en", en0, 0);
        tick(1);
        check("reactive_state", st0, 1);
        check("reactive_en", en0, 1);
        check("cool_ignore_cnt", cnt0, 1);

        // Wake strobe in the same cycle as hold expiry
        vad0 = 2'b00;
        tick(15);
        check("prio_en", en0, 1);
        pulse_wake0();
        check("prio_state", st0, 2);
        check("prio_count", cnt0, 2);

        // Saturation: 255 more wakes gives 257 total
        vad0 = 2'b01;
        for (int i = 0; i < 255; i++) begin
            wait_state0("sat_wait", 2'd1);
            pulse_wake0();
        end
        check("sat_count", cnt0, 255);

        // Reset during WAKE clears outputs asynchronously
        wait_state0("rst_wait", 2'd1);
        pulse_wake0();
        tick(1);
        check("pre_rst_wake", wake0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wake", wake0, 0);
        check("async_state", st0, 0);
        check("async_count", cnt0, 0);
        tick(1);
        rst_n = 1'b1;

        // AND combining on the second instance
        mask1 = 2'b11;
        vad1  = 2'b10;
        seen  = 1'b0;
        repeat (15) begin
            tick(1);
            seen |= en1;
        end
        check("and_partial", seen, 0);
        vad1 = 2'b11;
        tick(6);
        check("and_en_pre", en1, 0);
        tick(1);
        check("and_en", en1, 1);
        mask1 = 2'b00;
        tick(25);
        seen = 1'b0;
        repeat (20) begin
            tick(1);
            seen |= en1;
        end
        check("and_mask0", seen, 0);
        check("and_mask0_state", st1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
